// File: rtl/axi4_mem_arb_pkg.sv
// Shared types for the AXI4 slave memory arbiter: FSM states, side encoding
// and the width of one buffered write beat.
package axi4_mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WR   = 2'd1,
    ARB_RD   = 2'd2
  } arb_state_t;

  typedef enum logic {
    SIDE_WR = 1'b0,
    SIDE_RD = 1'b1
  } side_t;

  // One FIFO entry packs {addr, data, strb, last}.
  function automatic int fifo_entry_width(input int addr_width, input int data_width);
    return addr_width + data_width + data_width / 8 + 1;
  endfunction

endpackage

// File: rtl/axi4_sync_fifo.sv
// Synchronous FIFO with registered storage and no fall-through; a push into an
// empty FIFO becomes visible at the head on the following cycle.
module axi4_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LEVEL = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = store[rd_ptr];

  // NOTE: storage is deliberately not reset; the pointers and level define
  // which entries are meaningful, so clearing the array would only add logic.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/axi4_slave_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between buffered write
// beats and handshaked read beats. Define AXI4_ARB_BURST_LOCK_EN to hold the
// grant on one side until the beat carrying last is granted.
module axi4_slave_mem_arbiter
  import axi4_mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int WR_FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/8-1:0]          wr_strb,
  input  logic                             wr_last,
  output logic [$clog2(WR_FIFO_DEPTH):0]   wr_fifo_level,
  input  logic                             rd_req,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  input  logic                             rd_last,
  output logic                             rd_gnt,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_data_valid,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  output logic [DATA_WIDTH/8-1:0]          mem_be,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int ENTRY_W = fifo_entry_width(ADDR_WIDTH, DATA_WIDTH);

  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    head_entry;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [STRB_W-1:0]     head_strb;
  logic                  head_last;
  logic                  fifo_full;
  logic                  fifo_empty;

  arb_state_t state, next_state;
  side_t      last_served;
  logic       wr_pend, rd_pend;
  logic       rr_wr, rr_rd;
  logic       grant_wr, grant_rd;

  assign push_entry = {wr_addr, wr_data, wr_strb, wr_last};
  assign {head_addr, head_data, head_strb, head_last} = head_entry;
  assign wr_ready   = !fifo_full;

  axi4_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (WR_FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid),
    .push_data (push_entry),
    .pop       (grant_wr),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (wr_fifo_level)
  );

`ifdef AXI4_ARB_BURST_LOCK_EN
  logic  lock_active;
  side_t lock_side;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_active <= 1'b0;
      lock_side   <= SIDE_RD;
    end else if (grant_wr) begin
      lock_active <= !head_last;
      lock_side   <= SIDE_WR;
    end else if (grant_rd) begin
      lock_active <= !rd_last;
      lock_side   <= SIDE_RD;
    end
  end
`else
  // last only travels through the FIFO in the per-beat build.
  logic unused_last;
  assign unused_last = head_last ^ rd_last;
`endif

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave a value held and infer a latch.
  always_comb begin
    next_state = ARB_IDLE;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    wr_pend    = !fifo_empty;
    rd_pend    = rd_req;
    // Ties go to the side not served last.
    rr_wr      = wr_pend && (!rd_pend || last_served == SIDE_RD);
    rr_rd      = rd_pend && !rr_wr;
`ifdef AXI4_ARB_BURST_LOCK_EN
    if (lock_active) begin
      grant_wr = (lock_side == SIDE_WR) && wr_pend;
      grant_rd = (lock_side == SIDE_RD) && rd_pend;
    end else begin
      grant_wr = rr_wr;
      grant_rd = rr_rd;
    end
`else
    grant_wr = rr_wr;
    grant_rd = rr_rd;
`endif
    if (grant_wr)      next_state = ARB_WR;
    else if (grant_rd) next_state = ARB_RD;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ARB_IDLE;
      last_served <= SIDE_RD;
    end else begin
      state <= next_state;
      if (grant_wr)      last_served <= SIDE_WR;
      else if (grant_rd) last_served <= SIDE_RD;
    end
  end

  // The registered state is the access strobe for the current cycle.
  assign mem_en  = (state != ARB_IDLE);
  assign mem_we  = (state == ARB_WR);
  assign rd_gnt  = grant_rd;
  assign rd_data = mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= mem_en && !mem_we;
      if (grant_wr) begin
        mem_addr  <= head_addr;
        mem_wdata <= head_data;
        mem_be    <= head_strb;
      end else if (grant_rd) begin
        mem_addr  <= rd_addr;
        mem_wdata <= '0;
        mem_be    <= '0;
      end else begin
        mem_be    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem_arbiter.sv
// Scoreboard bench for axi4_slave_mem_arbiter: expected memory accesses and
// read data are queued as stimulus is accepted and compared as the DUT emits them.
`timescale 1ns/1ps
module tb_axi4_slave_mem_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int SW    = DW / 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [SW-1:0] wr_strb = '0;
  logic          wr_last = 1'b0;
  logic [LW-1:0] wr_fifo_level;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_last = 1'b0;
  logic          rd_gnt;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_be;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  axi4_slave_mem_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .WR_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .wr_last       (wr_last),
    .wr_fifo_level (wr_fifo_level),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_last       (rd_last),
    .rd_gnt        (rd_gnt),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_rdata     (mem_rdata)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] be;
  } acc_t;

  acc_t          wr_exp_q [$];
  logic [AW-1:0] rd_acc_q [$];
  logic [DW-1:0] rd_data_q [$];
  bit            we_trace [$];
  bit            abort = 1'b0;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] rd_pattern(input logic [AW-1:0] a);
    if (a == 32'h20) return 32'h1234_5678;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory: read data valid one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= rd_pattern(mem_addr);
  end

  always @(negedge clk) begin
    acc_t          e;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (rst) begin
      if (mem_en) begin
        we_trace.push_back(mem_we);
        if (mem_we) begin
          if (wr_exp_q.size() == 0) check("wr_unexpected", mem_we, 1'b0);
          else begin
            e = wr_exp_q.pop_front();
            check("wr_addr", mem_addr, e.addr);
            check("wr_data", mem_wdata, e.data);
            check("wr_be", mem_be, e.be);
          end
        end else begin
          if (rd_acc_q.size() == 0) check("rd_unexpected", mem_en, 1'b0);
          else begin
            a = rd_acc_q.pop_front();
            check("rd_addr", mem_addr, a);
            check("rd_be", mem_be, '0);
          end
        end
      end
      if (rd_data_valid) begin
        if (rd_data_q.size() == 0) check("rdv_unexpected", rd_data_valid, 1'b0);
        else begin
          d = rd_data_q.pop_front();
          check("rd_data", rd_data, d);
        end
      end
    end
  end

  task automatic push_beat(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input logic l);
    bit r;
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_strb = s; wr_last = l;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); r = wr_ready;
      @(posedge clk); #1;
      if (abort) begin wr_valid = 1'b0; return; end
      if (r) begin wr_exp_q.push_back('{a, d, s}); return; end
    end
    check("push_timeout", wr_ready, 1'b1);
  endtask

  task automatic read_burst(input logic [AW-1:0] base, input int beats);
    int k = 0;
    bit g;
    rd_req = 1'b1; rd_addr = base; rd_last = (beats == 1);
    for (int i = 0; i < 200 && k < beats; i++) begin
      @(negedge clk); g = rd_gnt;
      @(posedge clk); #1;
      if (abort) break;
      if (g) begin
        rd_acc_q.push_back(rd_addr);
        rd_data_q.push_back(rd_pattern(rd_addr));
        k++;
        rd_addr = base + AW'(4 * k);
        rd_last = (k == beats - 1);
      end
    end
    rd_req = 1'b0; rd_last = 1'b0;
    if (!abort) check("rd_burst_done", 64'(k), 64'(beats));
  endtask

  task automatic check_reset_values(input string p);
    check({p, "_mem_en"}, mem_en, 1'b0);
    check({p, "_mem_we"}, mem_we, 1'b0);
    check({p, "_mem_addr"}, mem_addr, '0);
    check({p, "_mem_wdata"}, mem_wdata, '0);
    check({p, "_mem_be"}, mem_be, '0);
    check({p, "_rd_gnt"}, rd_gnt, 1'b0);
    check({p, "_rd_dv"}, rd_data_valid, 1'b0);
    check({p, "_wr_ready"}, wr_ready, 1'b1);
    check({p, "_level"}, wr_fifo_level, '0);
  endtask

  task automatic do_reset();
    rst = 1'b0; wr_valid = 1'b0; rd_req = 1'b0; rd_last = 1'b0; wr_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    wr_exp_q.delete(); rd_acc_q.delete(); rd_data_q.delete();
    abort = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_we;
    bit         any_en;

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Single write: mem strobe two cycles after the push cycle.
    push_beat(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
    wr_valid = 1'b0;
    @(negedge clk);
    check("sw_n1_en", mem_en, 1'b0);
    @(negedge clk);
    check("sw_en", mem_en, 1'b1);
    check("sw_we", mem_we, 1'b1);
    check("sw_addr", mem_addr, 32'h10);
    check("sw_be", mem_be, 4'hF);
    repeat (2) @(posedge clk);
    #1;

    // Single read: grant now, strobe next cycle, data the cycle after.
    rd_req = 1'b1; rd_addr = 32'h20; rd_last = 1'b1;
    @(negedge clk);
    check("sr_gnt", rd_gnt, 1'b1);
    rd_acc_q.push_back(32'h20);
    rd_data_q.push_back(32'h1234_5678);
    @(posedge clk); #1;
    rd_req = 1'b0; rd_last = 1'b0;
    @(negedge clk);
    check("sr_en", mem_en, 1'b1);
    check("sr_we", mem_we, 1'b0);
    check("sr_addr", mem_addr, 32'h20);
    check("sr_be", mem_be, 4'h0);
    @(negedge clk);
    check("sr_dv", rd_data_valid, 1'b1);
    check("sr_data", rd_data, 32'h1234_5678);

    // Contention: 4 writes against a held 4-beat read.
    do_reset();
    we_trace.delete();
    fork
      begin
        for (int i = 0; i < 4; i++)
          push_beat(32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF, i == 3);
        wr_valid = 1'b0;
      end
      begin
        @(posedge clk); #1;
        read_burst(32'h200, 4);
      end
    join
    repeat (4) @(posedge clk);
    #1;
`ifdef AXI4_ARB_BURST_LOCK_EN
    exp_we = 8'b1111_0000;
`else
    exp_we = 8'b1010_1010;
`endif
    check("cont_len", 64'(we_trace.size()), 64'd8);
    for (int i = 0; i < 8 && i < we_trace.size(); i++)
      check($sformatf("cont_we%0d", i), we_trace[i], exp_we[7-i]);
    check("cont_wr_drained", 64'(wr_exp_q.size()), 64'd0);
    check("cont_rd_drained", 64'(rd_data_q.size()), 64'd0);

    // FIFO full, refused push during pop, then reset with entries queued.
    do_reset();
    fork
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 12 && !abort; i++)
          push_beat(32'h300 + 32'(4 * i), 32'hF00D_0000 + 32'(i), 4'h3, i == 11);
        wr_valid = 1'b0;
      end
      begin
        read_burst(32'h400, 12);
      end
      begin
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (wr_fifo_level == LW'(4)) break;
        end
        check("full_level", wr_fifo_level, 4);
        check("full_ready", wr_ready, 1'b0);
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (mem_en && mem_we) begin
            check("full_pop_refused", wr_fifo_level, 3);
            break;
          end
          check("full_hold", wr_fifo_level, 4);
        end
        abort = 1'b1;
        wr_valid = 1'b0; rd_req = 1'b0; rd_last = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_values("mid");
      end
    join
    repeat (2) @(posedge clk);
    #1;
    wr_exp_q.delete(); rd_acc_q.delete(); rd_data_q.delete();
    abort = 1'b0;
    @(negedge clk) rst = 1'b1;
    any_en = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      any_en = any_en | mem_en | rd_data_valid;
    end
    check("post_reset_idle", any_en, 1'b0);
    check("post_reset_level", wr_fifo_level, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
